prbs_err_link: RTL and testbench



---
 rtl/prbs_err_link_pkg.sv | 19 +
 rtl/prbs_err_link_if.sv | 26 ++
 rtl/prbs_err_link_bcd_sat_cnt4.sv | 45 ++++
 rtl/prbs_err_link.sv | 119 +++++++++++
 tb/tb_prbs_err_link.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/prbs_err_link_pkg.sv
// Shared constants for the PRBS7 error-injection link stage.
// Tap positions, defaults, checker state codes and BCD ceiling.
package prbs_err_link_pkg;

   localparam int         TAP_A    = 6;
   localparam int         TAP_B    = 5;
   localparam logic [6:0] DEF_SEED = 7'h7F;
   localparam int         DEF_LOL  = 8;

   localparam logic [0:0] ST_HUNT  = 1'b0;
   localparam logic [0:0] ST_LOCK  = 1'b1;

   localparam logic [15:0] BCD_MAX = 16'h9999;

   function automatic logic prbs7_fb(input logic [6:0] s);
      return s[TAP_A] ^ s[TAP_B];
   endfunction

endpackage

// File: rtl/prbs_err_link_if.sv
// Bit-stream, injection and status bundle of the error-injection link.
// The master side drives stimulus; the slave side is the link stage.
interface prbs_err_link_if;

   logic        EN;
   logic        ERROR;
   logic        BTN;
   logic        RX_EN;
   logic        RX_BIT;
   logic        CLR;
   logic        TX_BIT;
   logic        LOCK;
   logic        ERR_FLAG;
   logic [15:0] ERR_CNT;

   modport master (
      output EN, ERROR, BTN, RX_EN, RX_BIT, CLR,
      input  TX_BIT, LOCK, ERR_FLAG, ERR_CNT
   );

   modport slave (
      input  EN, ERROR, BTN, RX_EN, RX_BIT, CLR,
      output TX_BIT, LOCK, ERR_FLAG, ERR_CNT
   );

endinterface

// File: rtl/prbs_err_link_bcd_sat_cnt4.sv
// Four-digit BCD counter that saturates at 9999.
// Clear wins over increment in the same cycle.
module bcd_sat_cnt4
   import prbs_err_link_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_inc,
   input  logic        i_clr,
   output logic [15:0] o_cnt
);

   logic [15:0] r_cnt;
   logic [15:0] w_nxt;

   // Ripple carry: each digit wrapping 9->0 bumps the next one
   always_comb begin
      logic c;
      w_nxt = r_cnt;
      c     = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (r_cnt[4*i +: 4] == 4'd9) begin
               w_nxt[4*i +: 4] = 4'd0;
            end else begin
               w_nxt[4*i +: 4] = r_cnt[4*i +: 4] + 4'd1;
               c               = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != BCD_MAX)) begin
         r_cnt <= w_nxt;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/prbs_err_link.sv
// PRBS7 generator with single-bit error injection and a locking
// receive checker that counts bit errors in BCD.
module prbs_err_link
   import prbs_err_link_pkg::*;
#(
   parameter int         LOL_THRESH = DEF_LOL,
   parameter logic [6:0] SEED       = DEF_SEED
) (
   input logic            CLK,
   input logic            RST,
   prbs_err_link_if.slave bus
);

   localparam int RW = $clog2(LOL_THRESH + 1);

   logic [1:0]    r_sync;
   logic          r_btn_d;
   logic          w_btn_pls;
   logic          w_req;

   logic [6:0]    r_lfsr;
   logic          w_nb;
   logic          r_pend;
   logic          r_tx;

   logic [0:0]    r_state;
   logic [6:0]    r_sr;
   logic [2:0]    r_bcnt;
   logic [RW-1:0] r_run;
   logic          w_exp;
   logic          w_mis;
   logic          r_flag;

   assign w_btn_pls = r_sync[1] & ~r_btn_d;
   assign w_req     = bus.ERROR | w_btn_pls;
   assign w_nb      = prbs7_fb(r_lfsr);
   assign w_exp     = prbs7_fb(r_sr);
   assign w_mis     = bus.RX_EN & (r_state == ST_LOCK)
                    & (bus.RX_BIT != w_exp);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_sync  <= '0;
         r_btn_d <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], bus.BTN};
         r_btn_d <= r_sync[1];
      end
   end

   // A request arriving on a consuming cycle stays pending for the next bit
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_lfsr <= SEED;
         r_tx   <= 1'b0;
         r_pend <= 1'b0;
      end else if (bus.EN) begin
         r_lfsr <= {r_lfsr[5:0], w_nb};
         r_tx   <= w_nb ^ r_pend;
         r_pend <= w_req;
      end else begin
         r_pend <= r_pend | w_req;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= ST_HUNT;
         r_sr    <= '0;
         r_bcnt  <= '0;
         r_run   <= '0;
         r_flag  <= 1'b0;
      end else begin
         r_flag <= w_mis;
         if (bus.RX_EN) begin
            case (r_state)
               ST_HUNT: begin
                  r_sr <= {r_sr[5:0], bus.RX_BIT};
                  if (r_bcnt == 3'd6) begin
                     r_state <= ST_LOCK;
                     r_bcnt  <= '0;
                     r_run   <= '0;
                  end else begin
                     r_bcnt <= r_bcnt + 3'd1;
                  end
               end
               default: begin
                  // Locked: reference runs free, never reloaded from RX
                  r_sr <= {r_sr[5:0], w_exp};
                  if (w_mis) begin
                     if (r_run == RW'(LOL_THRESH - 1)) begin
                        r_state <= ST_HUNT;
                        r_bcnt  <= '0;
                        r_run   <= '0;
                     end else begin
                        r_run <= r_run + RW'(1);
                     end
                  end else begin
                     r_run <= '0;
                  end
               end
            endcase
         end
      end
   end

   bcd_sat_cnt4 u_cnt (
      .i_clk (CLK),
      .i_rst (RST),
      .i_inc (w_mis),
      .i_clr (bus.CLR),
      .o_cnt (bus.ERR_CNT)
   );

   assign bus.TX_BIT   = r_tx;
   assign bus.LOCK     = (r_state == ST_LOCK);
   assign bus.ERR_FLAG = r_flag;

endmodule

// File: tb/tb_prbs_err_link.sv
// Randomized and directed checks of prbs_err_link against a
// sequence-level model of the PRBS stream, injection and checker.
module tb_prbs_err_link;

   localparam int LOL = 8;

   logic clk = 1'b0;
   logic rst;

   prbs_err_link_if bus ();

   prbs_err_link dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   bit g[$];
   bit win[$];
   bit bh[3];
   bit m_pend, m_tx, m_lock, m_flag;
   int m_bcnt, m_run, m_errs;
   bit en_last;

   task automatic chk(input string tag,
                      input logic [15:0] obs,
                      input logic [15:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t",
                  tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10),
              4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic model_reset();
      g.delete();
      win.delete();
      repeat (7) g.push_back(1'b1);
      repeat (7) win.push_back(1'b0);
      bh      = '{0, 0, 0};
      m_pend  = 0;
      m_tx    = 0;
      m_lock  = 0;
      m_flag  = 0;
      m_bcnt  = 0;
      m_run   = 0;
      m_errs  = 0;
      en_last = 0;
   endtask

   // Stream bit n = bit(n-7) ^ bit(n-6); checker predicts the same way
   task automatic model_edge();
      bit pls, req, nb, e;
      pls   = bh[1] & ~bh[2];
      req   = bus.ERROR | pls;
      bh[2] = bh[1];
      bh[1] = bh[0];
      bh[0] = bus.BTN;
      if (bus.EN) begin
         nb = g[0] ^ g[1];
         g.push_back(nb);
         void'(g.pop_front());
         m_tx   = nb ^ m_pend;
         m_pend = req;
      end else begin
         m_pend = m_pend | req;
      end
      m_flag = 0;
      if (bus.RX_EN) begin
         if (!m_lock) begin
            win.push_back(bus.RX_BIT);
            void'(win.pop_front());
            m_bcnt++;
            if (m_bcnt == 7) begin
               m_lock = 1;
               m_bcnt = 0;
               m_run  = 0;
            end
         end else begin
            e = win[0] ^ win[1];
            win.push_back(e);
            void'(win.pop_front());
            if (bus.RX_BIT != e) begin
               m_flag = 1;
               if (m_errs < 9999) m_errs++;
               m_run++;
               if (m_run == LOL) begin
                  m_lock = 0;
                  m_bcnt = 0;
                  m_run  = 0;
               end
            end else begin
               m_run = 0;
            end
         end
      end
      en_last = bus.EN;
      if (bus.CLR) m_errs = 0;
   endtask

   task automatic cyc(input bit flip);
      bus.RX_EN  = en_last;
      bus.RX_BIT = m_tx ^ flip;
      @(posedge clk);
      model_edge();
      #1;
      chk("tx",   16'(bus.TX_BIT),   16'(m_tx));
      chk("lock", 16'(bus.LOCK),     16'(m_lock));
      chk("flag", 16'(bus.ERR_FLAG), 16'(m_flag));
      chk("cnt",  bus.ERR_CNT,       to_bcd(m_errs));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_tx"},   16'(bus.TX_BIT),   16'h0);
      chk({tag, "_lock"}, 16'(bus.LOCK),     16'h0);
      chk({tag, "_flag"}, 16'(bus.ERR_FLAG), 16'h0);
      chk({tag, "_cnt"},  bus.ERR_CNT,       16'h0);
   endtask

   task automatic first_seven(input string tag);
      logic [6:0] want;
      want = 7'b0000001;
      for (int i = 0; i < 7; i++) begin
         cyc(1'b0);
         chk(tag, 16'(bus.TX_BIT), 16'(want[6-i]));
      end
   endtask

   initial begin
      bit burst_on;
      int burst;
      rst        = 1'b1;
      bus.EN     = 1'b0;
      bus.ERROR  = 1'b0;
      bus.BTN    = 1'b0;
      bus.RX_EN  = 1'b0;
      bus.RX_BIT = 1'b0;
      bus.CLR    = 1'b0;
      model_reset();
      #3;
      chk_zero("rst");
      #9;
      rst = 1'b0;

      bus.EN = 1'b1;
      first_seven("tx_seq");
      repeat (1000) cyc(1'b0);
      chk("lock_up", 16'(bus.LOCK), 16'h1);
      chk("clean",   bus.ERR_CNT,   16'h0000);

      bus.ERROR = 1'b1;
      cyc(1'b0);
      bus.ERROR = 1'b0;
      repeat (20) cyc(1'b0);
      chk("one_err",  bus.ERR_CNT,   16'h0001);
      chk("one_lock", 16'(bus.LOCK), 16'h1);

      bus.EN    = 1'b0;
      bus.ERROR = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.BTN = (i >= 5 && i < 15);
         cyc(1'b0);
      end
      bus.EN    = 1'b1;
      bus.ERROR = 1'b0;
      bus.BTN   = 1'b0;
      repeat (30) cyc(1'b0);
      chk("collapse", bus.ERR_CNT, 16'h0002);

      for (int i = 0; i < 10005; i++) begin
         cyc(1'b1);
         cyc(1'b0);
      end
      chk("sat",      bus.ERR_CNT,   16'h9999);
      chk("sat_lock", 16'(bus.LOCK), 16'h1);
      bus.CLR = 1'b1;
      cyc(1'b1);
      bus.CLR = 1'b0;
      chk("clr",      bus.ERR_CNT,   16'h0000);
      chk("clr_lock", 16'(bus.LOCK), 16'h1);
      cyc(1'b0);

      repeat (LOL) cyc(1'b1);
      chk("lol_cnt",  bus.ERR_CNT,   16'h0008);
      chk("lol_lock", 16'(bus.LOCK), 16'h0);
      repeat (12) cyc(1'b0);
      chk("relock",   16'(bus.LOCK), 16'h1);

      burst_on = 0;
      burst    = 0;
      for (int i = 0; i < 4000; i++) begin
         bus.EN    = ($urandom_range(0, 3) != 0);
         bus.ERROR = ($urandom_range(0, 29) == 0);
         bus.CLR   = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 19) == 0) bus.BTN = ~bus.BTN;
         if (burst > 0) begin
            burst--;
            burst_on = 1;
         end else if ($urandom_range(0, 299) == 0) begin
            burst    = $urandom_range(1, 10);
            burst_on = 1;
         end else begin
            burst_on = ($urandom_range(0, 39) == 0);
         end
         cyc(burst_on);
      end

      #2;
      rst = 1'b1;
      #1;
      chk_zero("mid_rst");
      model_reset();
      bus.EN    = 1'b1;
      bus.ERROR = 1'b0;
      bus.BTN   = 1'b0;
      bus.CLR   = 1'b0;
      bus.RX_EN = 1'b0;
      #2;
      rst = 1'b0;
      first_seven("tx_rst");
      repeat (20) cyc(1'b0);
      chk("relock_rst", 16'(bus.LOCK), 16'h1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
